pps_gen: RTL and testbench

Pulse-per-second generator driven by the local real-time clock. It watches the free-running `sec`/`nsec` time-of-day bus and emits a 1 PPS output pulse at a programmable phase within each second. The pulse has a programmable width and feeds board-level PPS outputs or the PPS input of another clock domain. The block sits downstream of the RTC in the same `clk` domain and is the transmit-side counterpart of its PPS input.

---
 rtl/pps_gen_pkg.sv | 16 +
 rtl/pps_gen_boundary.sv | 29 ++
 rtl/pps_gen.sv | 130 +++++++++++++
 tb/tb_pps_gen.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pps_gen_pkg.sv
// Shared definitions for the PPS generator and related timestamping blocks.
package pps_gen_pkg;

  localparam int unsigned SEC_W  = 48;
  localparam int unsigned NSEC_W = 30;

  localparam logic [NSEC_W-1:0] NSEC_MODULO = 30'd1_000_000_000;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StArmed,
    StHigh
  } pps_state_e;

endpackage

// File: rtl/pps_gen_boundary.sv
// Second-boundary detector: tracks the previous RTC seconds value and flags
// changes and non-unit steps (forward skips, backward steps, 48-bit wrap aware).
module pps_gen_boundary
  import pps_gen_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [SEC_W-1:0] i_sec,
  output logic             o_sec_chg,
  output logic             o_sec_jump
);

  logic [SEC_W-1:0] r_sec_prev;
  logic [SEC_W-1:0] w_sec_inc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sec_prev <= '0;
    end else if (i_load) begin
      r_sec_prev <= i_sec;
    end
  end

  assign w_sec_inc  = r_sec_prev + SEC_W'(1);
  assign o_sec_chg  = (i_sec != r_sec_prev);
  assign o_sec_jump = o_sec_chg && (i_sec != w_sec_inc);

endmodule

// File: rtl/pps_gen.sv
// 1 PPS generator at a programmable phase and width, driven by the RTC sec/nsec bus.
// Optional PPS_GEN_TOD_EN adds o_tod_sec/o_tod_valid latched at each pulse rise.
module pps_gen
  import pps_gen_pkg::*;
#(
  parameter int unsigned PULSE_W_BITS = 16,
  parameter int unsigned CNT_BITS     = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic [NSEC_W-1:0]       i_offset_ns,
  input  logic [PULSE_W_BITS-1:0] i_width_clks,
  input  logic [SEC_W-1:0]        i_sec,
  input  logic [NSEC_W-1:0]       i_nsec,
  output logic                    o_pps_out,
  output logic [CNT_BITS-1:0]     o_pps_count,
  output logic [CNT_BITS-1:0]     o_jump_count
`ifdef PPS_GEN_TOD_EN
  ,
  output logic [SEC_W-1:0]        o_tod_sec,
  output logic                    o_tod_valid
`endif
);

  pps_state_e              r_state, w_state_d;
  logic [PULSE_W_BITS-1:0] r_wcnt, w_wcnt_d;
  logic                    r_chg_seen, w_chg_seen_d;
  logic                    r_pps;
  logic [CNT_BITS-1:0]     r_pps_count, r_jump_count;
  logic                    w_fire, w_hit, w_load, w_sec_chg, w_sec_jump;
  logic [PULSE_W_BITS-1:0] w_width_m1;

  assign w_load = (r_state != StIdle) || i_enable;

  pps_gen_boundary u_boundary (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_sec      (i_sec),
    .o_sec_chg  (w_sec_chg),
    .o_sec_jump (w_sec_jump)
  );

  assign w_hit      = (i_nsec >= i_offset_ns) && (i_offset_ns < NSEC_MODULO);
  assign w_width_m1 = (i_width_clks == '0) ? '0 : i_width_clks - PULSE_W_BITS'(1);

  always_comb begin
    w_state_d    = r_state;
    w_wcnt_d     = r_wcnt;
    w_chg_seen_d = r_chg_seen;
    w_fire       = 1'b0;
    unique case (r_state)
      StIdle:  if (i_enable) w_state_d = StWait;
      // Evaluating hit on the boundary cycle itself gives offset 0 a 1-clk latency.
      StWait: begin
        if (w_sec_chg) begin
          if (w_hit) w_fire = 1'b1;
          else       w_state_d = StArmed;
        end
      end
      StArmed: if (w_hit) w_fire = 1'b1;
      StHigh: begin
        if (w_sec_chg && w_hit) begin
          w_fire = 1'b1;
        end else begin
          if (w_sec_chg) w_chg_seen_d = 1'b1;
          if (r_wcnt == '0) begin
            w_state_d = (r_chg_seen || w_sec_chg) ? StArmed : StWait;
          end else begin
            w_wcnt_d = r_wcnt - PULSE_W_BITS'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_fire) begin
      w_state_d    = StHigh;
      w_wcnt_d     = w_width_m1;
      w_chg_seen_d = 1'b0;
    end
    if (!i_enable) begin
      w_state_d = StIdle;
      w_fire    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_wcnt       <= '0;
      r_chg_seen   <= 1'b0;
      r_pps        <= 1'b0;
      r_pps_count  <= '0;
      r_jump_count <= '0;
    end else begin
      r_state    <= w_state_d;
      r_wcnt     <= w_wcnt_d;
      r_chg_seen <= w_chg_seen_d;
      r_pps      <= (w_state_d == StHigh);
      if (w_fire) r_pps_count <= r_pps_count + CNT_BITS'(1);
      if (i_enable && (r_state != StIdle) && w_sec_jump) begin
        r_jump_count <= r_jump_count + CNT_BITS'(1);
      end
    end
  end

  assign o_pps_out    = r_pps;
  assign o_pps_count  = r_pps_count;
  assign o_jump_count = r_jump_count;

`ifdef PPS_GEN_TOD_EN
  logic [SEC_W-1:0] r_tod_sec;
  logic             r_tod_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tod_sec   <= '0;
      r_tod_valid <= 1'b0;
    end else begin
      r_tod_valid <= w_fire;
      if (w_fire) r_tod_sec <= i_sec;
    end
  end

  assign o_tod_sec   = r_tod_sec;
  assign o_tod_valid = r_tod_valid;
`endif

endmodule

// File: tb/tb_pps_gen.sv
// Directed bench for pps_gen with a stepped RTC model; honours PPS_GEN_TOD_EN if defined.
module tb_pps_gen;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [29:0] offset_ns;
  logic [15:0] width_clks;
  logic [47:0] sec;
  logic [29:0] nsec;
  logic        pps_out;
  logic [31:0] pps_count;
  logic [31:0] jump_count;
`ifdef PPS_GEN_TOD_EN
  logic [47:0] tod_sec;
  logic        tod_valid;
`endif

  int unsigned step;
  int unsigned n_cmp;
  int unsigned n_mis;
  int unsigned hi_cycles;
  int unsigned rises;
  logic        pps_prev;

  pps_gen #(
    .PULSE_W_BITS (16),
    .CNT_BITS     (32)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_offset_ns  (offset_ns),
    .i_width_clks (width_clks),
    .i_sec        (sec),
    .i_nsec       (nsec),
    .o_pps_out    (pps_out),
    .o_pps_count  (pps_count),
    .o_jump_count (jump_count)
`ifdef PPS_GEN_TOD_EN
    ,
    .o_tod_sec    (tod_sec),
    .o_tod_valid  (tod_valid)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    hi_cycles = 0;
    rises     = 0;
    pps_prev  = 1'b0;
  endtask

  // One clock: sample outputs just after the edge, then advance the RTC model.
  task automatic tick();
    logic [31:0] ns_next;
    @(posedge clk);
    #1;
    if (pps_out) begin
      hi_cycles++;
      if (!pps_prev) rises++;
    end
    pps_prev = pps_out;
    ns_next  = {2'b00, nsec} + step;
    if (ns_next >= 32'd1_000_000_000) begin
      ns_next = ns_next - 32'd1_000_000_000;
      sec     = sec + 48'd1;
    end
    nsec = ns_next[29:0];
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst_n  = 1'b0;
    #2;
    rst_n  = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    clear_mon();
    rst_n = 1'b0; enable = 1'b0; offset_ns = '0; width_clks = 16'd4;
    sec = 48'd5; nsec = 30'd999_999_960; step = 8;
    #12;
    check("rst_pps", pps_out, 0);
    check("rst_pps_count", pps_count, 0);
    check("rst_jump_count", jump_count, 0);
`ifdef PPS_GEN_TOD_EN
    check("rst_tod_sec", tod_sec, 0);
    check("rst_tod_valid", tod_valid, 0);
`endif
    rst_n = 1'b1;

    // Enable mid-second: no pulse until sec=6, then a 4-cycle pulse.
    enable = 1'b1;
    run(5);
    check("t1_no_partial_pps", pps_out, 0);
    check("t1_no_partial_rises", rises, 0);
    check("t1_no_partial_cnt", pps_count, 0);
    tick();
    check("t1_pps_rise", pps_out, 1);
    check("t1_pps_count", pps_count, 1);
`ifdef PPS_GEN_TOD_EN
    check("t1_tod_valid", tod_valid, 1);
    check("t1_tod_sec", tod_sec, 6);
`endif
    run(9);
    check("t1_width", hi_cycles, 4);
    check("t1_rises", rises, 1);
    check("t1_pps_count_end", pps_count, 1);

    // Offset 500 ms, width 1, three seconds at 10 clocks per second.
    do_reset();
    clear_mon();
    sec = 48'd100; nsec = '0; step = 100_000_000;
    offset_ns = 30'd500_000_000; width_clks = 16'd1;
    enable = 1'b1;
    run(15);
    check("t2_before_cross", pps_out, 0);
    tick();
    check("t2_at_cross", pps_out, 1);
    run(24);
    check("t2_rises", rises, 3);
    check("t2_hi_cycles", hi_cycles, 3);
    check("t2_pps_count", pps_count, 3);

    // Seconds jump 10->20 while armed, then 20->15.
    do_reset();
    clear_mon();
    sec = 48'd9; nsec = 30'd900_000_000; step = 100_000_000;
    offset_ns = 30'd500_000_000; width_clks = 16'd2;
    enable = 1'b1;
    run(2);
    check("t3_no_jump_unit", jump_count, 0);
    sec = 48'd20;
    tick();
    check("t3_jump_fwd", jump_count, 1);
    run(8);
    sec = 48'd15;
    tick();
    check("t3_jump_back", jump_count, 2);
    check("t3_rises", rises, 1);
    check("t3_hi_cycles", hi_cycles, 2);
    check("t3_pps_count", pps_count, 1);

    // Offset of one full second never fires.
    do_reset();
    clear_mon();
    sec = 48'd50; nsec = '0; step = 100_000_000;
    offset_ns = 30'd1_000_000_000; width_clks = 16'd1;
    enable = 1'b1;
    run(30);
    check("t4_rises", rises, 0);
    check("t4_pps_count", pps_count, 0);

    // Pulse longer than a shortened second reloads without a gap.
    do_reset();
    clear_mon();
    sec = 48'd7; nsec = 30'd999_900_000; step = 100_000;
    offset_ns = '0; width_clks = 16'hFFFF;
    enable = 1'b1;
    run(2);
    check("t5_first_fire", pps_out, 1);
    check("t5_count_first", pps_count, 1);
`ifdef PPS_GEN_TOD_EN
    check("t5_tod_sec_first", tod_sec, 8);
    check("t5_tod_valid_first", tod_valid, 1);
`endif
    run(10_000);
    check("t5_count_reload", pps_count, 2);
    check("t5_no_gap_rises", rises, 1);
    check("t5_hi_cycles", hi_cycles, 10_001);
`ifdef PPS_GEN_TOD_EN
    check("t5_tod_sec_reload", tod_sec, 9);
    check("t5_tod_valid_reload", tod_valid, 1);
    tick();
    check("t5_tod_valid_drop", tod_valid, 0);
`endif

    // Asynchronous reset mid-pulse.
    rst_n = 1'b0;
    #1;
    check("t6_reset_pps", pps_out, 0);
    check("t6_reset_pps_count", pps_count, 0);
    check("t6_reset_jump_count", jump_count, 0);
    #1;
    rst_n = 1'b1;

    // Disable mid-pulse: drops one clock later, counters held.
    clear_mon();
    enable = 1'b0;
    sec = 48'd30; nsec = 30'd999_900_000; step = 100_000;
    offset_ns = '0; width_clks = 16'd100;
    enable = 1'b1;
    run(7);
    check("t6_pulse_running", pps_out, 1);
    enable = 1'b0;
    #1;
    check("t6_pps_before_edge", pps_out, 1);
    tick();
    check("t6_pps_after_disable", pps_out, 0);
    run(20);
    check("t6_pps_stays_low", pps_out, 0);
    check("t6_count_held", pps_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
